instr_fetch: RTL and testbench

//  Instruction fetch sequencer for the BasicCPU front end. Holds the program counter.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch sequencer for the BasicCPU front end. Holds the program
//   counter, reads a two-byte instruction (opcode, then operand) over a
//   ready-based memory handshake, and presents the assembled instruction to
//   decode through a valid/ack handshake.
//
// Ports
//   clk          clock, all state changes on posedge
//   reset        synchronous, active-low reset
//   pc_load      load pc_load_val into pc and abort any fetch in progress
//   pc_load_val  jump target
//   halt         1 = do not start new fetches
//   mem_rd       read request, held until mem_rdy
//   mem_addr     read address, stable while mem_rd=1
//   mem_rdy      memory returns mem_data this cycle
//   mem_data     read data, sampled when mem_rd & mem_rdy
//   ir           {opcode, operand}, stable while ir_valid=1
//   ir_valid     ir holds a complete instruction
//   ir_ack       decode consumed ir
//   pc           address of the next byte to fetch
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pc_load,
    input  logic [ADDR_WIDTH-1:0]   pc_load_val,
    input  logic                    halt,
    output logic                    mem_rd,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_rdy,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    output logic [2*DATA_WIDTH-1:0] ir,
    output logic                    ir_valid,
    input  logic                    ir_ack,
    output logic [ADDR_WIDTH-1:0]   pc
);

    localparam int unsigned IR_WIDTH = 2 * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_RST = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        ARG  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Next sequential byte address; wraps silently at the top of memory.
    assign pc_inc = pc + ADDR_WIDTH'(1);

    // Fetch sequencer: reset > pc_load > normal handshake progress.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= PC_RST;
            mem_addr <= PC_RST;
            mem_rd   <= 1'b0;
            ir       <= IR_WIDTH'(0);
            ir_valid <= 1'b0;
        end else if (pc_load) begin
            // Jump aborts any fetch; a byte returned this cycle is discarded.
            state    <= IDLE;
            pc       <= pc_load_val;
            mem_addr <= pc_load_val;
            mem_rd   <= 1'b0;
            ir_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!halt) begin
                        state    <= OP;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                OP: begin
                    // Opcode byte; request stays up for the operand.
                    if (mem_rdy) begin
                        ir[IR_WIDTH-1:DATA_WIDTH] <= mem_data;
                        pc       <= pc_inc;
                        mem_addr <= pc_inc;
                        state    <= ARG;
                    end
                end
                ARG: begin
                    if (mem_rdy) begin
                        ir[DATA_WIDTH-1:0] <= mem_data;
                        pc       <= pc_inc;
                        mem_rd   <= 1'b0;
                        ir_valid <= 1'b1;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    // halt only gates the start of the next instruction.
                    if (ir_ack) begin
                        ir_valid <= 1'b0;
                        if (!halt) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= pc;
                            state    <= OP;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed scenarios plus a randomized run for instr_fetch. A second instance
//   with a reset PC near the top of memory exercises address wrap.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        pc_load;
    logic [7:0]  pc_load_val;
    logic        halt;
    logic        mem_rdy;
    logic        ir_ack;

    logic        mem_rd,   mem_rd_w;
    logic [7:0]  mem_addr, mem_addr_w;
    logic [7:0]  mem_data, mem_data_w;
    logic [15:0] ir,       ir_w;
    logic        ir_valid, ir_valid_w;
    logic [7:0]  pc,       pc_w;

    logic [7:0]  mem [256];

    int n_cmp;
    int n_fail;

    assign mem_data   = mem[mem_addr];
    assign mem_data_w = mem[mem_addr_w];

    instr_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(0)) u_dut (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .halt(halt), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
        .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack), .pc(pc)
    );

    instr_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(32'hFE)) u_dut_wrap (
        .clk(clk), .reset(reset), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .halt(halt), .mem_rd(mem_rd_w), .mem_addr(mem_addr_w), .mem_rdy(mem_rdy),
        .mem_data(mem_data_w), .ir(ir_w), .ir_valid(ir_valid_w), .ir_ack(ir_ack), .pc(pc_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic halt_v);
        reset = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;
        halt = halt_v; mem_rdy = 1'b1; ir_ack = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd act=%0h exp=0", mem_rd); end
        n_cmp++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL rst_ir act=%0h exp=0", ir); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid act=%0h exp=0", ir_valid); end
        n_cmp++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rst_pc act=%0h exp=0", pc); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr act=%0h exp=0", mem_addr); end
        n_cmp++; if (pc_w !== 8'hFE) begin n_fail++; $display("FAIL rst_pc_wrap act=%0h exp=fe", pc_w); end
        n_cmp++; if (mem_addr_w !== 8'hFE) begin n_fail++; $display("FAIL rst_addr_wrap act=%0h exp=fe", mem_addr_w); end
    endtask

    // Basic fetch latency from reset release, plus address wrap on the second instance.
    task automatic test_basic_and_wrap();
        logic [15:0] exp_w;
        exp_w = {mem[8'hFE], mem[8'hFF]};
        do_reset(1'b0);
        tick();
        n_cmp++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL t1_e1_rd act=%0h exp=1", mem_rd); end
        n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL t1_e1_addr act=%0h exp=0", mem_addr); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL t1_e1_valid act=%0h exp=0", ir_valid); end
        tick();
        n_cmp++; if (mem_addr_w !== 8'hFF) begin n_fail++; $display("FAIL t4_e2_addr act=%0h exp=ff", mem_addr_w); end
        n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL t1_e2_valid act=%0h exp=0", ir_valid); end
        tick();
        n_cmp++; if (ir !== 16'hA53C) begin n_fail++; $display("FAIL t1_e3_ir act=%0h exp=a53c", ir); end
        n_cmp++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL t1_e3_valid act=%0h exp=1", ir_valid); end
        n_cmp++; if (pc !== 8'h02) begin n_fail++; $display("FAIL t1_e3_pc act=%0h exp=2", pc); end
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL t1_e3_rd act=%0h exp=0", mem_rd); end
        n_cmp++; if (ir_w !== exp_w) begin n_fail++; $display("FAIL t4_ir act=%0h exp=%0h", ir_w, exp_w); end
        n_cmp++; if (pc_w !== 8'h00) begin n_fail++; $display("FAIL t4_pc_wrap act=%0h exp=0", pc_w); end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        n_cmp++; if (mem_rd_w !== 1'b1 || mem_addr_w !== 8'h00) begin n_fail++; $display("FAIL t4_next_fetch act=%0h/%0h exp=1/0", mem_rd_w, mem_addr_w); end
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h02 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL t1_next_fetch act=%0h/%0h/%0h exp=1/2/0", mem_rd, mem_addr, ir_valid); end
    endtask

    // Memory stalls during the operand read.
    task automatic test_stall();
        do_reset(1'b0);
        tick();
        tick();
        mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h01 || ir[15:8] !== 8'hA5 || ir_valid !== 1'b0) begin
                n_fail++; $display("FAIL t2_stall%0d act=rd%0h addr%0h hi%0h v%0h exp=rd1 addr1 hia5 v0", i, mem_rd, mem_addr, ir[15:8], ir_valid);
            end
        end
        mem_rdy = 1'b1;
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || ir !== 16'hA53C) begin n_fail++; $display("FAIL t2_done act=%0h/%0h exp=1/a53c", ir_valid, ir); end
    endtask

    // Jump together with ack while holding an instruction.
    task automatic test_load_with_ack();
        logic [15:0] exp_ir;
        exp_ir = {mem[8'h80], mem[8'h81]};
        pc_load = 1'b1; pc_load_val = 8'h80; ir_ack = 1'b1;
        tick();
        pc_load = 1'b0; ir_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || pc !== 8'h80 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL t3_load act=v%0h pc%0h rd%0h exp=v0 pc80 rd0", ir_valid, pc, mem_rd); end
        n_cmp++; if (ir !== 16'hA53C) begin n_fail++; $display("FAIL t3_ir_kept act=%0h exp=a53c", ir); end
        tick();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h80) begin n_fail++; $display("FAIL t3_fetch act=%0h/%0h exp=1/80", mem_rd, mem_addr); end
        tick();
        n_cmp++; if (ir[15:8] !== mem[8'h80] || mem_addr !== 8'h81) begin n_fail++; $display("FAIL t3_opcode act=%0h/%0h exp=%0h/81", ir[15:8], mem_addr, mem[8'h80]); end
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || ir !== exp_ir || pc !== 8'h82) begin n_fail++; $display("FAIL t3_done act=%0h/%0h/%0h exp=1/%0h/82", ir_valid, ir, pc, exp_ir); end
    endtask

    // halt holds off fetching; a started fetch completes.
    task automatic test_halt();
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (mem_rd !== 1'b0 || pc !== 8'h00) begin n_fail++; $display("FAIL t5_halted%0d act=%0h/%0h exp=0/0", i, mem_rd, pc); end
        end
        halt = 1'b0;
        tick();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin n_fail++; $display("FAIL t5_start act=%0h/%0h exp=1/0", mem_rd, mem_addr); end
        halt = 1'b1;
        tick();
        tick();
        n_cmp++; if (ir_valid !== 1'b1 || ir !== 16'hA53C) begin n_fail++; $display("FAIL t5_complete act=%0h/%0h exp=1/a53c", ir_valid, ir); end
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        n_cmp++; if (ir_valid !== 1'b0 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL t5_ack_idle act=%0h/%0h exp=0/0", ir_valid, mem_rd); end
        tick();
        tick();
        n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL t5_stay_idle act=%0h exp=0", mem_rd); end
        halt = 1'b0;
        tick();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h02) begin n_fail++; $display("FAIL t5_resume act=%0h/%0h exp=1/2", mem_rd, mem_addr); end
    endtask

    // Reset during the operand read drops the request.
    task automatic test_reset_mid();
        tick();
        n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 8'h03) begin n_fail++; $display("FAIL t6_in_arg act=%0h/%0h exp=1/3", mem_rd, mem_addr); end
        reset = 1'b0;
        tick();
        reset = 1'b1; halt = 1'b1;
        n_cmp++; if (mem_rd !== 1'b0 || ir !== 16'h0 || ir_valid !== 1'b0 || pc !== 8'h00) begin
            n_fail++; $display("FAIL t6_reset act=rd%0h ir%0h v%0h pc%0h exp=rd0 ir0 v0 pc0", mem_rd, ir, ir_valid, pc);
        end
        n_cmp++; if (pc_w !== 8'hFE) begin n_fail++; $display("FAIL t6_reset_wrap act=%0h exp=fe", pc_w); end
    endtask

    // Random traffic against a byte-stream model: pc tracks the byte address,
    // every two accepted bytes form one instruction, a jump restarts the stream.
    task automatic test_random();
        logic [7:0]  exp_pc;
        logic [7:0]  bytes [2];
        int          nbytes;
        logic        p_rd, p_valid, p_halt, p_load, p_rdy, p_ack;
        logic [7:0]  p_addr, p_val;
        logic [15:0] p_ir;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        do_reset(1'b0);
        exp_pc = 8'h00;
        nbytes = 0;
        for (int c = 0; c < 3000; c++) begin
            halt        = ($urandom_range(0, 9) < 3);
            mem_rdy     = ($urandom_range(0, 9) < 6);
            ir_ack      = ($urandom_range(0, 1) == 1);
            pc_load     = ($urandom_range(0, 99) < 3);
            pc_load_val = 8'($urandom);
            p_rd = mem_rd; p_valid = ir_valid; p_halt = halt; p_load = pc_load;
            p_rdy = mem_rdy; p_ack = ir_ack; p_addr = mem_addr; p_val = pc_load_val; p_ir = ir;
            if (!p_load && p_rd && p_rdy) begin
                n_cmp++; if (p_addr !== exp_pc) begin n_fail++; $display("FAIL rnd_addr c%0d act=%0h exp=%0h", c, p_addr, exp_pc); end
            end
            tick();
            if (p_load) begin
                exp_pc = p_val;
                nbytes = 0;
                n_cmp++; if (ir_valid !== 1'b0 || mem_rd !== 1'b0 || ir !== p_ir) begin
                    n_fail++; $display("FAIL rnd_load c%0d act=v%0h rd%0h ir%0h exp=v0 rd0 ir%0h", c, ir_valid, mem_rd, ir, p_ir);
                end
            end else if (p_rd && p_rdy) begin
                bytes[nbytes] = mem[p_addr];
                nbytes++;
                exp_pc = exp_pc + 8'd1;
                if (nbytes == 2) begin
                    nbytes = 0;
                    n_cmp++; if (ir_valid !== 1'b1 || mem_rd !== 1'b0 || ir !== {bytes[0], bytes[1]}) begin
                        n_fail++; $display("FAIL rnd_instr c%0d act=v%0h rd%0h ir%0h exp=v1 rd0 ir%0h", c, ir_valid, mem_rd, ir, {bytes[0], bytes[1]});
                    end
                end else begin
                    n_cmp++; if (ir_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== exp_pc) begin
                        n_fail++; $display("FAIL rnd_opcode c%0d act=v%0h rd%0h addr%0h exp=v0 rd1 addr%0h", c, ir_valid, mem_rd, mem_addr, exp_pc);
                    end
                end
            end else if (p_valid && p_ack) begin
                n_cmp++; if (ir_valid !== 1'b0 || mem_rd !== !p_halt || (!p_halt && mem_addr !== exp_pc)) begin
                    n_fail++; $display("FAIL rnd_ack c%0d act=v%0h rd%0h addr%0h exp=v0 rd%0h addr%0h", c, ir_valid, mem_rd, mem_addr, !p_halt, exp_pc);
                end
            end else if (p_valid) begin
                n_cmp++; if (ir_valid !== 1'b1 || ir !== p_ir || mem_rd !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_hold c%0d act=v%0h ir%0h rd%0h exp=v1 ir%0h rd0", c, ir_valid, ir, mem_rd, p_ir);
                end
            end else if (p_rd) begin
                n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== p_addr || ir_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_stall c%0d act=rd%0h addr%0h v%0h exp=rd1 addr%0h v0", c, mem_rd, mem_addr, ir_valid, p_addr);
                end
            end else begin
                n_cmp++; if (mem_rd !== !p_halt || ir_valid !== 1'b0 || (!p_halt && mem_addr !== exp_pc)) begin
                    n_fail++; $display("FAIL rnd_idle c%0d act=rd%0h v%0h addr%0h exp=rd%0h v0 addr%0h", c, mem_rd, ir_valid, mem_addr, !p_halt, exp_pc);
                end
            end
            n_cmp++; if (pc !== exp_pc) begin n_fail++; $display("FAIL rnd_pc c%0d act=%0h exp=%0h", c, pc, exp_pc); end
        end
        pc_load = 1'b0; ir_ack = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset = 1'b0; pc_load = 1'b0; pc_load_val = 8'h00;
        halt = 1'b1; mem_rdy = 1'b0; ir_ack = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
        mem[8'h00] = 8'hA5;
        mem[8'h01] = 8'h3C;
        #2;
        test_reset();
        test_basic_and_wrap();
        test_stall();
        test_load_with_ack();
        test_halt();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
